leaf_out_sched: RTL and testbench

//  Round-robin, credit-based scheduler that shares the single leaf->BFT output link among NUM_OUT_PORTS user output streams.

---
 rtl/leaf_out_sched.sv | 185 ++++++++++++++++++
 tb/tb_leaf_out_sched.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_out_sched.sv
// Round-robin, credit-based scheduler that packs user output words into BFT packets.
// Optional per-port transfer counters on stat_cnt when LEAF_SCHED_STATS_EN is defined.
//
// state  | meaning
// S_IDLE | no port enabled yet, waiting for the first cfg_wr
// S_RUN  | arbitrating eligible ports into the output register
// S_STALL| valid packet held while the link is not ready
module leaf_out_sched #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int NUM_OUT_PORTS = 4,
  localparam int PW = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1,
  localparam int CW = NUM_ADDR_BITS + 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_user,
  input  logic [NUM_OUT_PORTS-1:0]                vld_user,
  output logic [NUM_OUT_PORTS-1:0]                ack_user,
  output logic [PACKET_BITS-1:0]                  pkt_out,
  input  logic                                    link_rdy,
  input  logic                                    cfg_wr,
  input  logic [PW-1:0]                           cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]                cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0]                cfg_dport,
  input  logic                                    crd_vld,
  input  logic [PW-1:0]                           crd_port,
  input  logic [CW-1:0]                           crd_amt,
  output logic                                    crd_err
`ifdef LEAF_SCHED_STATS_EN
  ,
  output logic [NUM_OUT_PORTS*32-1:0]             stat_cnt
`endif
);

  localparam logic [CW-1:0] CRD_MAX = {1'b1, {NUM_ADDR_BITS{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STALL} state_t;

  state_t                     state_q, state_d;
  logic [PACKET_BITS-1:0]     pkt_q, pkt_d;
  logic [NUM_OUT_PORTS-1:0]   en_q, en_d;
  logic [NUM_LEAF_BITS-1:0]   leaf_q  [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0]   leaf_d  [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0]   dport_q [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0]   dport_d [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0]   addr_q  [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0]   addr_d  [NUM_OUT_PORTS];
  logic [CW-1:0]              crd_q   [NUM_OUT_PORTS];
  logic [CW-1:0]              crd_d   [NUM_OUT_PORTS];
  logic [PW-1:0]              rr_q, rr_d;
  logic                       err_q, err_d;
`ifdef LEAF_SCHED_STATS_EN
  logic [31:0]                stat_q  [NUM_OUT_PORTS];
  logic [31:0]                stat_d  [NUM_OUT_PORTS];
`endif

  logic                       slot_free;
  logic [NUM_OUT_PORTS-1:0]   elig;
  logic                       gnt_raw, gnt_vld;
  logic [PW-1:0]              gnt_idx;
  logic [CW:0]                crd_sum;

  assign slot_free = ~pkt_q[PACKET_BITS-1] | link_rdy;
  assign pkt_out   = pkt_q;
  assign crd_err   = err_q;

  // First eligible port at or above the rr pointer, wrapping around.
  always_comb begin
    gnt_raw = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      elig[i] = vld_user[i] & en_q[i] & (crd_q[i] != '0);
    end
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      if (!gnt_raw && elig[(int'(rr_q) + k) % NUM_OUT_PORTS]) begin
        gnt_raw = 1'b1;
        gnt_idx = PW'((int'(rr_q) + k) % NUM_OUT_PORTS);
      end
    end
    gnt_vld = gnt_raw & slot_free & (state_q != S_IDLE);
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      ack_user[i] = gnt_vld && (gnt_idx == PW'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    en_d    = en_q;
    leaf_d  = leaf_q;
    dport_d = dport_q;
    addr_d  = addr_q;
    crd_d   = crd_q;
    rr_d    = rr_q;
    err_d   = err_q;
    crd_sum = '0;
`ifdef LEAF_SCHED_STATS_EN
    stat_d  = stat_q;
`endif

    if (cfg_wr) begin
      en_d[cfg_port]    = 1'b1;
      leaf_d[cfg_port]  = cfg_leaf;
      dport_d[cfg_port] = cfg_dport;
    end

    // Dest fields come from the _q copies, so a same-cycle cfg_wr only affects later words.
    if (gnt_vld) begin
      pkt_d = {1'b1, leaf_q[gnt_idx], dport_q[gnt_idx], addr_q[gnt_idx],
               din_user[gnt_idx*PAYLOAD_BITS +: PAYLOAD_BITS]};
      addr_d[gnt_idx] = addr_q[gnt_idx] + 1'b1;
      rr_d = (gnt_idx == PW'(NUM_OUT_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
`ifdef LEAF_SCHED_STATS_EN
      stat_d[gnt_idx] = stat_q[gnt_idx] + 32'd1;
`endif
    end else if (slot_free) begin
      pkt_d[PACKET_BITS-1] = 1'b0;
    end

    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      crd_sum = {1'b0, crd_q[i]};
      if (crd_vld && (crd_port == PW'(i))) crd_sum = crd_sum + {1'b0, crd_amt};
      if (gnt_vld && (gnt_idx == PW'(i)))  crd_sum = crd_sum - 1'b1;
      if (crd_sum > {1'b0, CRD_MAX}) begin
        crd_d[i] = CRD_MAX;
        err_d    = 1'b1;
      end else begin
        crd_d[i] = crd_sum[CW-1:0];
      end
    end

    case (state_q)
      S_IDLE:  if (cfg_wr) state_d = S_RUN;
      S_RUN:   if (pkt_q[PACKET_BITS-1] && !link_rdy) state_d = S_STALL;
      S_STALL: if (link_rdy) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pkt_q   <= '0;
      en_q    <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        leaf_q[i]  <= '0;
        dport_q[i] <= '0;
        addr_q[i]  <= '0;
        crd_q[i]   <= CRD_MAX;
`ifdef LEAF_SCHED_STATS_EN
        stat_q[i]  <= '0;
`endif
      end
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      en_q    <= en_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
      leaf_q  <= leaf_d;
      dport_q <= dport_d;
      addr_q  <= addr_d;
      crd_q   <= crd_d;
`ifdef LEAF_SCHED_STATS_EN
      stat_q  <= stat_d;
`endif
    end
  end

`ifdef LEAF_SCHED_STATS_EN
  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      stat_cnt[i*32 +: 32] = stat_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_leaf_out_sched.sv
// Scoreboard bench for leaf_out_sched: directed stimulus pushes expected packets,
// a negedge monitor pops one whenever the link consumes a valid pkt_out.
module tb_leaf_out_sched;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N*32-1:0] din_user;
  logic [N-1:0]  vld_user;
  logic [N-1:0]  ack_user;
  logic [48:0]   pkt_out;
  logic          link_rdy;
  logic          cfg_wr;
  logic [1:0]    cfg_port;
  logic [4:0]    cfg_leaf;
  logic [3:0]    cfg_dport;
  logic          crd_vld;
  logic [1:0]    crd_port;
  logic [7:0]    crd_amt;
  logic          crd_err;
`ifdef LEAF_SCHED_STATS_EN
  logic [N*32-1:0] stat_cnt;
`endif

  leaf_out_sched dut (
    .clk(clk), .reset(reset), .din_user(din_user), .vld_user(vld_user),
    .ack_user(ack_user), .pkt_out(pkt_out), .link_rdy(link_rdy),
    .cfg_wr(cfg_wr), .cfg_port(cfg_port), .cfg_leaf(cfg_leaf), .cfg_dport(cfg_dport),
    .crd_vld(crd_vld), .crd_port(crd_port), .crd_amt(crd_amt), .crd_err(crd_err)
`ifdef LEAF_SCHED_STATS_EN
    , .stat_cnt(stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [48:0] sb[$];
  logic [48:0] mon_exp;
  logic [48:0] exp_x;
  logic [4:0]  leaf_m  [N];
  logic [3:0]  dport_m [N];
  logic [6:0]  addr_m  [N];
  int          ord [8] = '{1, 2, 3, 0, 1, 2, 3, 0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [48:0] mk(input int p, input logic [31:0] d);
    return {1'b1, leaf_m[p], dport_m[p], addr_m[p], d};
  endfunction

  task automatic push(input int p, input logic [31:0] d);
    sb.push_back(mk(p, d));
    addr_m[p] = addr_m[p] + 7'd1;
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
  endtask

  // Monitor: every consumed packet must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && pkt_out[48] && link_rdy) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got %h expected no packet at %0t", pkt_out, $time);
      end else begin
        mon_exp = sb.pop_front();
        chk("pkt", {15'd0, pkt_out}, {15'd0, mon_exp});
      end
    end
  end

  task automatic clear_model();
    sb.delete();
    for (int i = 0; i < N; i++) addr_m[i] = '0;
  endtask

  // Called from posedge+1; returns at posedge+1.
  task automatic do_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic cfg(input int p, input logic [4:0] l, input logic [3:0] dp);
    cfg_wr = 1'b1; cfg_port = 2'(p); cfg_leaf = l; cfg_dport = dp;
    @(posedge clk);
    #1 cfg_wr = 1'b0;
    leaf_m[p] = l;
    dport_m[p] = dp;
  endtask

  task automatic cfg_all();
    cfg(0, 5'd3, 4'd2);
    cfg(1, 5'd17, 4'd5);
    cfg(2, 5'd30, 4'd9);
    cfg(3, 5'd8, 4'd15);
  endtask

  // One cycle: drive word d on port p, check its ack, push expectation if accepted.
  task automatic cyc(input int p, input logic [31:0] d, input logic exp_ack);
    din_user[p*32 +: 32] = d;
    @(negedge clk);
    chk($sformatf("ack_p%0d", p), {63'd0, ack_user[p]}, {63'd0, exp_ack});
    if (exp_ack) push(p, d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; din_user = '0; vld_user = '0; link_rdy = 1'b1;
    cfg_wr = 1'b0; cfg_port = '0; cfg_leaf = '0; cfg_dport = '0;
    crd_vld = 1'b0; crd_port = '0; crd_amt = '0;
    for (int i = 0; i < N; i++) begin leaf_m[i] = '0; dport_m[i] = '0; end
    clear_model();
    #1;
    chk("rst_pkt", {15'd0, pkt_out}, 64'd0);
    chk("rst_ack", {60'd0, ack_user}, 64'd0);
    chk("rst_err", {63'd0, crd_err}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    vld_user = 4'b1111;
    @(negedge clk);
    chk("ack_disabled", {60'd0, ack_user}, 64'd0);
    @(posedge clk);
    #1 vld_user = '0;

    // Test 1: single word on port0
    cfg(0, 5'd3, 4'd2);
    vld_user = 4'b0010;
    @(negedge clk);
    chk("ack_unconfigured", {60'd0, ack_user}, 64'd0);
    @(posedge clk);
    #1 vld_user = 4'b0001;
    cyc(0, 32'hDEADBEEF, 1'b1);
    vld_user = '0;
    @(negedge clk);
    chk("t1_pkt", {15'd0, pkt_out}, {15'd0, 1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF});
    @(posedge clk);
    #1;
    cfg(1, 5'd17, 4'd5);
    cfg(2, 5'd30, 4'd9);
    cfg(3, 5'd8, 4'd15);

    // Test 2: round robin with all ports valid; rr starts at 1 after test 1
    for (int i = 0; i < N; i++) din_user[i*32 +: 32] = 32'hA000_0000 | i;
    vld_user = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("rr_ack_%0d", k), {60'd0, ack_user}, 64'(4'b0001 << ord[k]));
      push(ord[k], 32'hA000_0000 | ord[k]);
      @(posedge clk);
      #1;
    end
    vld_user = '0;

    // Test 3: exhaust port1 credits, address wrap, return 4 credits
    do_reset();
    cfg_all();
    vld_user = 4'b0010;
    for (int w = 0; w < 128; w++) cyc(1, 32'h1000_0000 + w, 1'b1);
    repeat (2) cyc(1, 32'h1BAD_0000, 1'b0);
    crd_vld = 1'b1; crd_port = 2'd1; crd_amt = 8'd4;
    cyc(1, 32'h1BAD_0001, 1'b0);
    crd_vld = 1'b0;
    for (int w = 0; w < 4; w++) cyc(1, 32'h2000_0000 + w, 1'b1);
    repeat (2) cyc(1, 32'h2BAD_0000, 1'b0);
    vld_user = '0;

    // Test 4: link stall holds the packet; grant on the release cycle
    vld_user = 4'b0100;
    exp_x = mk(2, 32'h4444_0001);
    cyc(2, 32'h4444_0001, 1'b1);
    link_rdy = 1'b0;
    din_user[2*32 +: 32] = 32'h4444_0002;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall_pkt_%0d", k), {15'd0, pkt_out}, {15'd0, exp_x});
      chk($sformatf("stall_ack_%0d", k), {60'd0, ack_user}, 64'd0);
      @(posedge clk);
      #1;
    end
    link_rdy = 1'b1;
    cyc(2, 32'h4444_0002, 1'b1);
    vld_user = '0;

    // Test 5: net credit update, overflow error, credit still 128
    vld_user = 4'b1000;
    crd_vld = 1'b1; crd_port = 2'd3; crd_amt = 8'd1;
    cyc(3, 32'h5555_0000, 1'b1);
    crd_vld = 1'b0;
    vld_user = '0;
    chk("crd_net_no_err", {63'd0, crd_err}, 64'd0);
    crd_vld = 1'b1;
    @(posedge clk);
    #1 crd_vld = 1'b0;
    chk("crd_overflow_err", {63'd0, crd_err}, 64'd1);
    vld_user = 4'b1000;
    for (int w = 0; w < 128; w++) cyc(3, 32'h5555_0100 + w, 1'b1);
    cyc(3, 32'h5BAD_0000, 1'b0);
    vld_user = '0;
    chk("crd_err_sticky", {63'd0, crd_err}, 64'd1);

    // Test 6: asynchronous reset with a packet in flight
    vld_user = 4'b0001;
    cyc(0, 32'h6666_0000, 1'b1);
    link_rdy = 1'b0;
    vld_user = '0;
    @(negedge clk);
    #2 reset = 1'b1;
    clear_model();
    #1;
    chk("midrst_pkt", {15'd0, pkt_out}, 64'd0);
    chk("midrst_err", {63'd0, crd_err}, 64'd0);
    chk("midrst_ack", {60'd0, ack_user}, 64'd0);
`ifdef LEAF_SCHED_STATS_EN
    chk("midrst_stat", {32'd0, stat_cnt[31:0] | stat_cnt[63:32] | stat_cnt[95:64] | stat_cnt[127:96]}, 64'd0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    link_rdy = 1'b1;
    vld_user = 4'b1111;
    @(negedge clk);
    chk("postrst_disabled", {60'd0, ack_user}, 64'd0);
    @(posedge clk);
    #1 vld_user = '0;
    cfg_all();
    for (int i = 0; i < N; i++) din_user[i*32 +: 32] = 32'h7777_0000 | i;
    vld_user = 4'b1111;
    @(negedge clk);
    chk("postrst_rr0", {60'd0, ack_user}, 64'd1);
    push(0, 32'h7777_0000);
    @(posedge clk);
    #1 vld_user = '0;
`ifdef LEAF_SCHED_STATS_EN
    chk("stat_p0", {32'd0, stat_cnt[31:0]}, 64'd1);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    summary();
    $finish;
  end

endmodule
